// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port sequencer/arbiter for one asynchronous 32-bit SRAM bank.
//
// The instruction-fetch port (read-only) and the data-memory port share the SRAM.
// Requests are accepted in IDLE. When both ports are eligible, the port that was
// not granted last time wins. The block then runs fixed strobe sequences:
//   read : RD1 -> RD2 -> IDLE          (data captured leaving RD2)
//   write: WR1 -> WR2 -> WR3 -> IDLE   (we_n low only in WR2)
// A one-cycle registered ack is returned on the edge leaving RD2 or WR3.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   if_req/if_addr/if_rdata/if_ack    instruction read port
//   mem_req/mem_we/mem_addr/mem_be/
//   mem_wdata/mem_rdata/mem_ack       data port (read or byte-masked write)
//   ram_addr/ram_data/ram_be_n/
//   ram_ce_n/ram_oe_n/ram_we_n        SRAM pins (strobes active-low)
//   busy                              high whenever the sequencer is not IDLE
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ack,
  output logic [ADDR_W-1:0]   ram_addr,
  inout  wire  [DATA_W-1:0]   ram_data,
  output logic [DATA_W/8-1:0] ram_be_n,
  output logic                ram_ce_n,
  output logic                ram_oe_n,
  output logic                ram_we_n,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_WR1,
    S_WR2,
    S_WR3
  } state_t;

  typedef enum logic {
    P_IF,
    P_MEM
  } port_t;

  state_t              state_q, state_d;
  port_t               last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W/8-1:0] be_n_q, be_n_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic                ce_n_q, oe_n_q, we_n_q, drv_q;

  logic if_elig, mem_elig, grant_mem;

  // A port whose ack is high this cycle is not eligible, so a request still
  // held on its own ack cycle is not accepted twice.
  assign if_elig   = if_req & ~if_ack_q;
  assign mem_elig  = mem_req & ~mem_ack_q;
  assign grant_mem = mem_elig & (~if_elig | (last_q == P_IF));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    be_n_d      = be_n_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          last_d = P_MEM;
          addr_d = mem_addr;
          if (mem_we) begin
            be_n_d  = ~mem_be;
            wdata_d = mem_wdata;
            state_d = S_WR1;
          end else begin
            be_n_d  = '0;
            state_d = S_RD1;
          end
        end else if (if_elig) begin
          last_d  = P_IF;
          addr_d  = if_addr;
          be_n_d  = '0;
          state_d = S_RD1;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        state_d = S_IDLE;
        if (last_q == P_IF) begin
          if_rdata_d = ram_data;
          if_ack_d   = 1'b1;
        end else begin
          mem_rdata_d = ram_data;
          mem_ack_d   = 1'b1;
        end
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: begin
        state_d   = S_IDLE;
        mem_ack_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so the SRAM pins never see
  // decode glitches; timing is identical to decoding the current state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_q      <= P_IF;
      addr_q      <= '0;
      be_n_q      <= '1;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      be_n_q      <= be_n_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      ce_n_q      <= (state_d == S_IDLE);
      oe_n_q      <= !((state_d == S_RD1) || (state_d == S_RD2));
      we_n_q      <= (state_d != S_WR2);
      drv_q       <= (state_d == S_WR1) || (state_d == S_WR2) || (state_d == S_WR3);
    end
  end

  assign ram_data  = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a behavioural SRAM.
// Stimulus pushes the expected (port, rdata) of each transaction; a monitor
// branch pops and compares on every ack.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [19:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n;
  logic        busy;

  sram_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM (low 256 words are enough here)
  logic [31:0] sram [256];
  assign ram_data = (ram_ce_n == 1'b0 && ram_oe_n == 1'b0 && ram_we_n == 1'b1)
                    ? sram[ram_addr[7:0]] : 32'bz;

  // Strobe activity counters, sampled mid-cycle
  int ce_cnt = 0, oe_cnt = 0, we_cnt = 0, bef_cnt = 0, viol_cnt = 0;
  always @(negedge clk) begin
    if (!ram_ce_n) ce_cnt <= ce_cnt + 1;
    if (!ram_oe_n) oe_cnt <= oe_cnt + 1;
    if (!ram_we_n) we_cnt <= we_cnt + 1;
    if (!ram_ce_n && ram_be_n == 4'hF) bef_cnt <= bef_cnt + 1;
    if (!ram_we_n && !ram_oe_n) viol_cnt <= viol_cnt + 1;
  end

  typedef struct packed {
    logic        port;   // 0 = if, 1 = mem
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic run_reset();
    rst = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at the negedge where the request was raised; returns at the ack negedge.
  task automatic wait_ack(input logic port, input int exp_lat, input string name);
    int  n = 0;
    bit  seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (port ? mem_ack : if_ack) seen = 1;
    end
    check({name, "_latency"}, seen ? n : 999, exp_lat);
  endtask

  task automatic do_read(input logic port, input logic [19:0] addr,
                         input logic [31:0] exp, input string name);
    push(port, exp);
    if (port) begin
      mem_we = 1'b0; mem_addr = addr; mem_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    wait_ack(port, 3, name);
    if (port) mem_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic [31:0] exp_rdata,
                          input string name);
    push(1'b1, exp_rdata);
    mem_we = 1'b1; mem_addr = addr; mem_be = be; mem_wdata = data; mem_req = 1'b1;
    wait_ack(1'b1, 4, name);
    mem_req = 1'b0;
  endtask

  initial begin
    int ce0, oe0, we0, bef0, n, mcnt, icnt;
    exp_t e;

    for (int unsigned i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h10] = 32'hDEADBEEF;
    sram[8'h20] = 32'h11223344;
    sram[8'h30] = 32'hCAFEF00D;
    sram[8'h40] = 32'h01234567;
    sram[8'h41] = 32'h89ABCDEF;
    sram[8'h50] = 32'h55555555;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0;
    mem_be = '0; mem_wdata = '0; rst = 0;

    fork
      // SRAM write: byte lanes latched on the rising edge of we_n
      forever begin
        @(posedge ram_we_n);
        if (ram_ce_n == 1'b0)
          for (int b = 0; b < 4; b++)
            if (!ram_be_n[b]) sram[ram_addr[7:0]][8*b +: 8] = ram_data[8*b +: 8];
      end
      // Monitor: compare every ack against the scoreboard
      forever begin
        @(negedge clk);
        if (rst && (if_ack || mem_ack)) begin
          check("ack_overlap", {31'b0, if_ack & mem_ack}, 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_ack", {31'b0, mem_ack}, {31'b0, ~mem_ack});
          end else begin
            e = sb.pop_front();
            check("ack_port", {31'b0, mem_ack}, {31'b0, e.port});
            check("ack_rdata", mem_ack ? mem_rdata : if_rdata, e.data);
          end
        end
      end
    join_none

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check("rst_be_n", {28'b0, ram_be_n}, 32'hF);
    check("rst_addr", {12'b0, ram_addr}, 32'h0);
    check("rst_ack_busy", {29'b0, if_ack, mem_ack, busy}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single read on the instruction port
    oe0 = oe_cnt;
    do_read(1'b0, 20'h00010, 32'hDEADBEEF, "single_read");
    check("single_read_oe_cycles", oe_cnt - oe0, 2);
    @(negedge clk);

    // Byte write; mem_rdata keeps its reset value across a write
    we0 = we_cnt;
    do_write(20'h00020, 4'b0101, 32'hAABBCCDD, 32'h0, "byte_write");
    check("byte_write_we_cycles", we_cnt - we0, 1);
    check("byte_write_sram", sram[8'h20], 32'h11BB33DD);
    @(negedge clk);
    do_read(1'b1, 20'h00020, 32'h11BB33DD, "readback");
    @(negedge clk);

    // Zero byte enables: full sequence, no lanes written
    ce0 = ce_cnt; bef0 = bef_cnt;
    do_write(20'h00030, 4'b0000, 32'h12345678, 32'h11BB33DD, "zero_be");
    check("zero_be_ce_cycles", ce_cnt - ce0, 3);
    check("zero_be_be_n_ones", bef_cnt - bef0, 3);
    check("zero_be_sram", sram[8'h30], 32'hCAFEF00D);
    @(negedge clk);

    // Held request across ack: exactly one SRAM read
    ce0 = ce_cnt;
    push(1'b0, 32'hDEADBEEF);
    if_addr = 20'h00010; if_req = 1'b1;
    wait_ack(1'b0, 3, "held_req");
    @(negedge clk);
    if_req = 1'b0;
    repeat (4) @(negedge clk);
    check("held_req_ce_cycles", ce_cnt - ce0, 2);

    // Simultaneous requests from reset: mem, if, mem, if
    run_reset();
    push(1'b1, 32'h01234567);
    push(1'b0, 32'h89ABCDEF);
    push(1'b1, 32'h01234567);
    push(1'b0, 32'h89ABCDEF);
    mem_we = 1'b0; mem_addr = 20'h00040; if_addr = 20'h00041;
    mem_req = 1'b1; if_req = 1'b1;
    n = 0; mcnt = 0; icnt = 0;
    while (n < 30 && (mcnt < 2 || icnt < 2)) begin
      @(negedge clk);
      n++;
      if (mem_ack) begin mcnt++; if (mcnt == 2) mem_req = 1'b0; end
      if (if_ack)  begin icnt++; if (icnt == 2) if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("simul_done_cycles", n, 12);
    @(negedge clk);

    // Reset during WR2: access abandoned, no ack
    mem_we = 1'b1; mem_addr = 20'h00050; mem_be = 4'hF; mem_wdata = 32'h12345678;
    mem_req = 1'b1;
    repeat (2) @(negedge clk);
    check("midwr_in_wr2_we_n", {31'b0, ram_we_n}, 32'h0);
    rst = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check("midwr_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
    check("midwr_busy_ack", {30'b0, busy, mem_ack}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("midwr_mem_rdata", mem_rdata, 32'h0);
    do_read(1'b0, 20'h00010, 32'hDEADBEEF, "post_reset_read");
    repeat (3) @(negedge clk);

    check("pending_expected", sb.size(), 0);
    check("we_oe_overlap", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
